// File: rtl/csi_rx_capture_ctrl.sv
// Capture sequencer for the CSI-2 receive datapath: soft-reset hold, LP-idle arming,
// host-gated frame capture, line/frame counting and stalled-line recovery.
module csi_rx_capture_ctrl #(
    parameter logic [7:0]  RST_CYCLES   = 8'd255,
    parameter logic [7:0]  LP_MIN       = 8'd16,
    parameter logic [15:0] LINE_TIMEOUT = 16'd8192,
    parameter logic [15:0] EXP_LINES    = 16'd0
) (
    input  logic        clock,
    input  logic        areset_n,
    input  logic        enable,
    input  logic        capture_req,
    input  logic        continuous,
    input  logic        err_clear,
    input  logic        in_frame,
    input  logic        in_line,
    input  logic        payload_enable,
    input  logic        lp_detect,
    output logic        dp_sreset,
    output logic        capture_en,
    output logic        frame_done,
    output logic [15:0] line_count,
    output logic [15:0] frame_count,
    output logic        err_line_timeout,
    output logic        err_line_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LP    = 3'd1,
        IDLE       = 3'd2,
        ARMED      = 3'd3,
        CAPTURE    = 3'd4,
        RECOVER    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold_cnt, hold_cnt_d;
    logic [7:0]  lp_cnt, lp_cnt_d;
    logic [15:0] stall_cnt, stall_cnt_d;
    logic        in_frame_q, in_line_q;

    logic        dp_sreset_d, capture_en_d, frame_done_d;
    logic [15:0] line_count_d, frame_count_d, line_count_final;
    logic        err_line_timeout_d, err_line_count_d;

    logic frame_rise, frame_fall, line_fall;
    logic hold_done, lp_done, stalling, timeout;

    assign frame_rise = in_frame & ~in_frame_q;
    assign frame_fall = ~in_frame & in_frame_q;
    assign line_fall  = ~in_line & in_line_q;

    assign hold_done = (hold_cnt == RST_CYCLES - 8'd1);
    assign lp_done   = lp_detect && (lp_cnt == LP_MIN - 8'd1);
    assign stalling  = in_line && !payload_enable;
    assign timeout   = (state_q == CAPTURE) && stalling && (stall_cnt == LINE_TIMEOUT - 16'd1);

    // A line ending in the same cycle as the frame is counted before the frame check.
    assign line_count_final = (line_fall && line_count != 16'hFFFF) ? line_count + 16'd1
                                                                    : line_count;

    assign state = state_q;

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) state_q <= RESET_HOLD;
        else           state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            RESET_HOLD: if (hold_done) state_d = WAIT_LP;
            WAIT_LP:    if (lp_done) state_d = IDLE;
            IDLE:       if (enable && (capture_req || continuous)) state_d = ARMED;
            ARMED:      if (frame_rise) state_d = CAPTURE;
            CAPTURE: begin
                if (timeout)         state_d = RECOVER;
                else if (frame_fall) state_d = (enable && continuous) ? ARMED : IDLE;
            end
            RECOVER:    state_d = RESET_HOLD;
            default:    state_d = RESET_HOLD;
        endcase
    end

    always_comb begin
        dp_sreset_d   = (state_d == RESET_HOLD);
        capture_en_d  = (state_d == CAPTURE);
        frame_done_d  = (state_q == CAPTURE) && frame_fall && !timeout;
        hold_cnt_d    = (state_q == RESET_HOLD && !hold_done) ? hold_cnt + 8'd1 : 8'd0;
        lp_cnt_d      = (state_q == WAIT_LP && lp_detect && !lp_done) ? lp_cnt + 8'd1 : 8'd0;
        stall_cnt_d   = (state_q == CAPTURE && stalling && !timeout) ? stall_cnt + 16'd1 : 16'd0;

        line_count_d = line_count;
        if (state_q == ARMED && frame_rise) line_count_d = 16'd0;
        else if (state_q == CAPTURE)        line_count_d = line_count_final;

        frame_count_d = frame_done_d ? frame_count + 16'd1 : frame_count;

        // A new error in the same cycle as err_clear keeps the flag set.
        err_line_timeout_d = (err_line_timeout && !err_clear) || timeout;
        err_line_count_d   = (err_line_count && !err_clear) ||
                             (frame_done_d && EXP_LINES != 16'd0 && line_count_final != EXP_LINES);
    end

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            dp_sreset        <= 1'b1;
            capture_en       <= 1'b0;
            frame_done       <= 1'b0;
            line_count       <= 16'd0;
            frame_count      <= 16'd0;
            err_line_timeout <= 1'b0;
            err_line_count   <= 1'b0;
            hold_cnt         <= 8'd0;
            lp_cnt           <= 8'd0;
            stall_cnt        <= 16'd0;
            in_frame_q       <= 1'b0;
            in_line_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            dp_sreset        <= dp_sreset_d;
            capture_en       <= capture_en_d;
            frame_done       <= frame_done_d;
            line_count       <= line_count_d;
            frame_count      <= frame_count_d;
            err_line_timeout <= err_line_timeout_d;
            err_line_count   <= err_line_count_d;
            hold_cnt         <= hold_cnt_d;
            lp_cnt           <= lp_cnt_d;
            stall_cnt        <= stall_cnt_d;
            in_frame_q       <= in_frame;
            in_line_q        <= in_line;
        end
    end

endmodule
